audio_lane_scheduler: RTL and testbench

Time-multiplexes 24-bit audio samples over a single 8-bit encoder/noisy-medium/decoder lane, replacing three parallel byte lanes with one. Accepts a sample on a valid/ready input, serializes it LSB-byte first into the lane, and captures each decoded byte after the lane's fixed latency. Reassembles the sample with an error flag and presents it on a valid/ready output. Maintains a saturating count of lane byte errors for link-quality monitoring.

---
 rtl/audio_link_pkg.sv | 33 +++
 rtl/sat_counter.sv | 19 +
 rtl/audio_lane_scheduler.sv | 145 ++++++++++++++
 tb/tb_audio_lane_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_link_pkg.sv
// Shared types and constants for the 24-bit audio sample lane scheduler.
package audio_link_pkg;

    localparam int unsigned SAMPLE_W         = 24;
    localparam int unsigned LANE_W           = 8;
    localparam int unsigned BYTES_PER_SAMPLE = 3;
    localparam int unsigned IDX_W            = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [LANE_W-1:0] get_byte(input logic [SAMPLE_W-1:0] s,
                                                   input logic [IDX_W-1:0]    idx);
        get_byte = '0;
        for (int unsigned k = 0; k < BYTES_PER_SAMPLE; k++) begin
            if (idx == IDX_W'(k)) get_byte = s[k*LANE_W +: LANE_W];
        end
    endfunction

    function automatic logic [SAMPLE_W-1:0] put_byte(input logic [SAMPLE_W-1:0] s,
                                                     input logic [IDX_W-1:0]    idx,
                                                     input logic [LANE_W-1:0]   b);
        put_byte = s;
        for (int unsigned k = 0; k < BYTES_PER_SAMPLE; k++) begin
            if (idx == IDX_W'(k)) put_byte[k*LANE_W +: LANE_W] = b;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/audio_lane_scheduler.sv
// Serializes 24-bit samples over one 8-bit lane and reassembles them with an error flag.
// Optional byte retransmission on lane errors is enabled by defining LANE_RETRY_EN.
module audio_lane_scheduler
    import audio_link_pkg::*;
#(
    parameter int unsigned LANE_LATENCY = 2,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [SAMPLE_W-1:0]  i_in_data,
    output logic                 o_lane_tx_valid,
    output logic [LANE_W-1:0]    o_lane_tx_data,
    input  logic [LANE_W-1:0]    i_lane_rx_data,
    input  logic                 i_lane_rx_error,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [SAMPLE_W-1:0]  o_out_data,
    output logic                 o_out_error,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic                 o_busy
);

    localparam int unsigned WAIT_W  = $clog2(LANE_LATENCY) + 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);
`ifdef LANE_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_e               r_state, w_next_state;
    logic [SAMPLE_W-1:0]  r_sample, w_sample_nx;
    logic [IDX_W-1:0]     r_idx, w_idx_nx;
    logic [RETRY_W-1:0]   r_retry, w_retry_nx;
    logic [WAIT_W-1:0]    r_wait, w_wait_nx;
    logic                 r_samp_err, w_samp_err_nx;
    logic                 w_accept, w_capture, w_retry, w_release;
    logic                 w_tx_valid_nx, w_out_valid_nx, w_out_error_nx;
    logic [LANE_W-1:0]    w_tx_data_nx;
    logic [SAMPLE_W-1:0]  w_out_data_nx;

    assign w_accept  = (r_state == ST_IDLE) && i_in_valid && o_in_ready;
    // The lane response is only trusted on the exact cycle it is due.
    assign w_capture = (r_state == ST_WAIT) && (r_wait == '0);
    assign w_retry   = w_capture && RETRY_EN && i_lane_rx_error &&
                       (r_retry < RETRY_W'(MAX_RETRY));
    assign w_release = (r_state == ST_DONE) && o_out_valid && i_out_ready;

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_reset),
        .i_inc   (w_capture && i_lane_rx_error),
        .o_count (o_err_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_SEND;
            ST_SEND: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_capture) begin
                    if (w_retry || (r_idx != LAST_IDX)) w_next_state = ST_SEND;
                    else                                w_next_state = ST_DONE;
                end
            end
            ST_DONE: if (w_release) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values so they carry no input-to-output path.
    always_comb begin
        w_sample_nx   = r_sample;
        w_idx_nx      = r_idx;
        w_retry_nx    = r_retry;
        w_wait_nx     = r_wait;
        w_samp_err_nx = r_samp_err;
        if (w_accept) begin
            w_sample_nx   = i_in_data;
            w_idx_nx      = '0;
            w_retry_nx    = '0;
            w_samp_err_nx = 1'b0;
        end
        if (r_state == ST_SEND) w_wait_nx = WAIT_W'(LANE_LATENCY - 1);
        if ((r_state == ST_WAIT) && !w_capture) w_wait_nx = r_wait - WAIT_W'(1);
        if (w_capture) begin
            if (w_retry) begin
                w_retry_nx = r_retry + RETRY_W'(1);
            end else begin
                w_sample_nx   = put_byte(r_sample, r_idx, i_lane_rx_data);
                w_samp_err_nx = r_samp_err | i_lane_rx_error;
                w_retry_nx    = '0;
                if (r_idx != LAST_IDX) w_idx_nx = r_idx + IDX_W'(1);
            end
        end

        w_tx_valid_nx  = (w_next_state == ST_SEND);
        w_tx_data_nx   = w_tx_valid_nx ? get_byte(w_sample_nx, w_idx_nx) : '0;
        w_out_valid_nx = (w_next_state == ST_DONE);
        w_out_data_nx  = w_out_valid_nx ? w_sample_nx : '0;
        w_out_error_nx = w_out_valid_nx && w_samp_err_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sample        <= '0;
            r_idx           <= '0;
            r_retry         <= '0;
            r_wait          <= '0;
            r_samp_err      <= 1'b0;
            o_in_ready      <= 1'b0;
            o_lane_tx_valid <= 1'b0;
            o_lane_tx_data  <= '0;
            o_out_valid     <= 1'b0;
            o_out_data      <= '0;
            o_out_error     <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            r_sample        <= w_sample_nx;
            r_idx           <= w_idx_nx;
            r_retry         <= w_retry_nx;
            r_wait          <= w_wait_nx;
            r_samp_err      <= w_samp_err_nx;
            o_in_ready      <= (w_next_state == ST_IDLE);
            o_lane_tx_valid <= w_tx_valid_nx;
            o_lane_tx_data  <= w_tx_data_nx;
            o_out_valid     <= w_out_valid_nx;
            o_out_data      <= w_out_data_nx;
            o_out_error     <= w_out_error_nx;
            o_busy          <= (w_next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_audio_lane_scheduler.sv
// Directed bench for audio_lane_scheduler with a behavioural fixed-latency lane model.
module tb_audio_lane_scheduler;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = 24'h0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data = 8'hEE;
    logic        rx_error = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_error;
    logic [15:0] err_count;
    logic        busy;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          tx_n = 0;
    int          bad_zero = 0;
    int          out_cyc;
    logic [31:0] lane_mask = 32'h0;
    logic        pv [0:LAT];
    logic [7:0]  pd [0:LAT];
    logic        pe [0:LAT];
    int          tx_cyc [$];
    logic [7:0]  tx_dat [$];

    audio_lane_scheduler dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_data       (in_data),
        .o_lane_tx_valid (tx_valid),
        .o_lane_tx_data  (tx_data),
        .i_lane_rx_data  (rx_data),
        .i_lane_rx_error (rx_error),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_data      (out_data),
        .o_out_error     (out_error),
        .o_err_count     (err_count),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: lane responds L cycles after a tx strobe; idle slots carry garbage flagged as errors.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
            pe[i] = pe[i-1];
        end
        pv[0] = tx_valid;
        pd[0] = tx_data;
        pe[0] = tx_valid && (tx_n < 32) && lane_mask[tx_n];
        if (tx_valid) begin
            tx_cyc.push_back(cyc);
            tx_dat.push_back(tx_data);
            tx_n++;
        end else if (tx_data !== 8'h00) begin
            bad_zero++;
        end
        if (pv[LAT]) begin
            rx_data  = pe[LAT] ? (pd[LAT] ^ 8'hFF) : pd[LAT];
            rx_error = pe[LAT];
        end else begin
            rx_data  = 8'hEE;
            rx_error = 1'b1;
        end
    endtask

    task automatic start_sample(input logic [23:0] d, input logic [31:0] mask);
        lane_mask = mask;
        tx_n = 0;
        bad_zero = 0;
        tx_cyc.delete();
        tx_dat.delete();
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        cyc = 0;
        tick();
        in_valid = 1'b0;
        in_data  = 24'hFFFFFF;
    endtask

    task automatic run_sample(input logic [23:0] d, input logic [31:0] mask);
        int n;
        start_sample(d, mask);
        out_cyc = -1;
        n = 0;
        while (out_cyc < 0 && n < 60) begin
            if (out_valid) out_cyc = cyc;
            else tick();
            n++;
        end
        chk("tx_data_zero_when_idle", 32'(bad_zero), 32'd0);
    endtask

    task automatic exp_tx(input int k, input int c, input logic [7:0] d);
        int       oc;
        logic [7:0] od;
        oc = (k < tx_cyc.size()) ? tx_cyc[k] : -1;
        od = (k < tx_dat.size()) ? tx_dat[k] : 8'hXX;
        chk($sformatf("tx%0d_cycle", k), 32'(oc), 32'(c));
        chk($sformatf("tx%0d_data", k), 32'(od), 32'(d));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        chk("out_valid_after_release", 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = 8'h00;
            pe[i] = 1'b0;
        end

        // Reset values
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Error-free sample
        run_sample(24'hA1B2C3, 32'h0);
        chk("A_tx_count", 32'(tx_cyc.size()), 32'd3);
        exp_tx(0, 1, 8'hC3);
        exp_tx(1, 4, 8'hB2);
        exp_tx(2, 7, 8'hA1);
        chk("A_out_cycle", 32'(out_cyc), 32'd10);
        chk("A_out_data", 32'(out_data), 32'hA1B2C3);
        chk("A_out_error", 32'(out_error), 32'd0);
        chk("A_err_count", 32'(err_count), 32'd0);
        chk("A_busy", 32'(busy), 32'd1);

        // Downstream back-pressure holds the result
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data", 32'(out_data), 32'hA1B2C3);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        release_out();

        // Single error on the first reception of byte 1
        run_sample(24'hA1B2C3, 32'h2);
`ifdef LANE_RETRY_EN
        chk("B_tx_count", 32'(tx_cyc.size()), 32'd4);
        exp_tx(1, 4, 8'hB2);
        exp_tx(2, 7, 8'hB2);
        exp_tx(3, 10, 8'hA1);
        chk("B_out_cycle", 32'(out_cyc), 32'd13);
        chk("B_out_data", 32'(out_data), 32'hA1B2C3);
        chk("B_out_error", 32'(out_error), 32'd0);
`else
        chk("B_tx_count", 32'(tx_cyc.size()), 32'd3);
        exp_tx(1, 4, 8'hB2);
        exp_tx(2, 7, 8'hA1);
        chk("B_out_cycle", 32'(out_cyc), 32'd10);
        chk("B_out_data", 32'(out_data), 32'hA14DC3);
        chk("B_out_error", 32'(out_error), 32'd1);
`endif
        chk("B_err_count", 32'(err_count), 32'd1);
        release_out();
        pulse_reset();
        chk("B_err_count_cleared", 32'(err_count), 32'd0);

        // Byte 0 errored on every reception
`ifdef LANE_RETRY_EN
        run_sample(24'hA1B2C3, 32'hF);
        chk("C_tx_count", 32'(tx_cyc.size()), 32'd6);
        exp_tx(0, 1, 8'hC3);
        exp_tx(3, 10, 8'hC3);
        exp_tx(4, 13, 8'hB2);
        chk("C_out_cycle", 32'(out_cyc), 32'd19);
        chk("C_err_count", 32'(err_count), 32'd4);
`else
        run_sample(24'hA1B2C3, 32'h1);
        chk("C_tx_count", 32'(tx_cyc.size()), 32'd3);
        exp_tx(1, 4, 8'hB2);
        chk("C_out_cycle", 32'(out_cyc), 32'd10);
        chk("C_err_count", 32'(err_count), 32'd1);
`endif
        chk("C_out_data", 32'(out_data), 32'hA1B23C);
        chk("C_out_error", 32'(out_error), 32'd1);
        release_out();

        // Reset during WAIT of byte 1
        pulse_reset();
`ifdef LANE_RETRY_EN
        start_sample(24'hDEADBE, 32'h0);
`else
        start_sample(24'hDEADBE, 32'h1);
`endif
        for (int k = 0; k < 4; k++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
`ifdef LANE_RETRY_EN
        chk("mid_err_count", 32'(err_count), 32'd0);
`else
        chk("mid_err_count", 32'(err_count), 32'd1);
`endif
        reset = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_post_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mid_late_rx_ignored", 32'(err_count), 32'd0);

        run_sample(24'h123456, 32'h0);
        chk("D_tx_count", 32'(tx_cyc.size()), 32'd3);
        exp_tx(0, 1, 8'h56);
        exp_tx(2, 7, 8'h12);
        chk("D_out_cycle", 32'(out_cyc), 32'd10);
        chk("D_out_data", 32'(out_data), 32'h123456);
        chk("D_out_error", 32'(out_error), 32'd0);
        chk("D_err_count", 32'(err_count), 32'd0);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
